// File: rtl/up_down_counter.sv
// Wrapping binary up/down counter with a direction select.
// Steps once per clock; the count register drives the output directly.
module up_down_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up_down,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // Next count: +1 when counting up, -1 when counting down.
  // The sum is WIDTH bits wide, so it wraps at both ends.
  always_comb begin
    count_d = count_q;
    if (up_down) begin
      count_d = count_q + WIDTH'(1);
    end else begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Count register with a synchronous reset that overrides the direction input.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_up_down_counter.sv
// Directed testbench for up_down_counter: reset, up and down counting, wrap at both ends,
// a reset in mid-count, and a direction change on every edge.
module tb_up_down_counter;

  logic       clk;
  logic       reset;
  logic       up_down;
  logic [3:0] count;

  int total;
  int bad;

  logic [3:0] exp_cnt;

  up_down_counter #(
    .WIDTH(4)
  ) u_dut (
    .clk    (clk),
    .reset  (reset),
    .up_down(up_down),
    .count  (count)
  );

  // First rising edge at 5 ns, then one every 10 ns.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog in case the run never gets to the summary line.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [3:0] expected);
    total++;
    assert (count === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, count, expected);
    end
  endtask

  // Change inputs on the falling edge, then check 1 ns after the next rising edge.
  task automatic step(input logic rst, input logic dir, input string tag,
                      input logic [3:0] expected);
    @(negedge clk);
    reset   = rst;
    up_down = dir;
    @(posedge clk);
    #1;
    check(tag, expected);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    up_down = 1'b1;

    // Reset over the 5 ns edge.
    @(posedge clk);
    #1;
    check("reset_first", 4'b0000);
    step(1'b1, 1'b1, "reset_hold_up", 4'b0000);
    step(1'b1, 1'b0, "reset_hold_down", 4'b0000);

    // Count up ten edges: 0001 .. 1010.
    exp_cnt = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      exp_cnt = exp_cnt + 4'd1;
      step(1'b0, 1'b1, "count_up", exp_cnt);
    end
    check("count_up_end", 4'b1010);

    // Count down ten edges: 1001 .. 0000.
    for (int i = 0; i < 10; i++) begin
      exp_cnt = exp_cnt - 4'd1;
      step(1'b0, 1'b0, "count_down", exp_cnt);
    end
    check("count_down_end", 4'b0000);

    // Up 16 edges from zero: 1111 after the 15th, wrap to 0000 on the 16th.
    for (int i = 1; i <= 15; i++) begin
      exp_cnt = exp_cnt + 4'd1;
      step(1'b0, 1'b1, "wrap_up_climb", exp_cnt);
    end
    check("wrap_up_top", 4'b1111);
    step(1'b0, 1'b1, "wrap_up_to_zero", 4'b0000);

    // Down from zero wraps to all ones.
    step(1'b0, 1'b0, "wrap_down_to_max", 4'b1111);

    // Climb back to 0111 counting up, then reset for one edge.
    step(1'b0, 1'b1, "climb_0", 4'b0000);
    step(1'b0, 1'b1, "climb_1", 4'b0001);
    step(1'b0, 1'b1, "climb_2", 4'b0010);
    step(1'b0, 1'b1, "climb_3", 4'b0011);
    step(1'b0, 1'b1, "climb_4", 4'b0100);
    step(1'b0, 1'b1, "climb_5", 4'b0101);
    step(1'b0, 1'b1, "climb_6", 4'b0110);
    step(1'b0, 1'b1, "climb_7", 4'b0111);
    step(1'b1, 1'b1, "mid_reset", 4'b0000);
    step(1'b0, 1'b1, "after_reset", 4'b0001);

    // Reset while counting down from a nonzero value.
    step(1'b0, 1'b1, "pre_reset_dn_a", 4'b0010);
    step(1'b1, 1'b0, "mid_reset_down", 4'b0000);
    step(1'b0, 1'b0, "after_reset_down", 4'b1111);

    // Get to 0101, then toggle direction on every edge.
    step(1'b1, 1'b1, "reset_again", 4'b0000);
    step(1'b0, 1'b1, "to5_1", 4'b0001);
    step(1'b0, 1'b1, "to5_2", 4'b0010);
    step(1'b0, 1'b1, "to5_3", 4'b0011);
    step(1'b0, 1'b1, "to5_4", 4'b0100);
    step(1'b0, 1'b1, "to5_5", 4'b0101);
    step(1'b0, 1'b1, "toggle_up_0", 4'b0110);
    step(1'b0, 1'b0, "toggle_dn_0", 4'b0101);
    step(1'b0, 1'b1, "toggle_up_1", 4'b0110);
    step(1'b0, 1'b0, "toggle_dn_1", 4'b0101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
